// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: CPU-wide default
// widths and the fetch controller state encodings.
package fetch_prefetch_unit_pkg;

    localparam int DEF_BITS_DATA = 32;
    localparam int DEF_BITS_ADDR = 16;

    localparam logic S_RUN  = 1'b0;
    localparam logic S_HALT = 1'b1;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding fetched {ir_pc, ir} entries; flush overrides push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module prefetch_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW:0]      count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; consumers must qualify head with count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !flush && count_q == (PW+1)'(DEPTH)));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher: issues sequential memory reads, buffers returned words
// with their addresses and hands them to decode over a valid/ready handshake.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int                   BITS_DATA = DEF_BITS_DATA,
    parameter int                   BITS_ADDR = DEF_BITS_ADDR,
    parameter int                   DEPTH     = 4,
    parameter logic [BITS_ADDR-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [BITS_ADDR-1:0] MAR,
    output logic                 mem_req,
    input  logic                 mem_grant,
    input  logic [BITS_DATA-1:0] MBR_R,
    input  logic                 redirect,
    input  logic [BITS_ADDR-1:0] redirect_pc,
    input  logic                 halt,
    output logic                 ir_valid,
    output logic [BITS_DATA-1:0] ir,
    output logic [BITS_ADDR-1:0] ir_pc,
    input  logic                 ir_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 2;
    localparam int EW = BITS_ADDR + BITS_DATA;

    logic                 state_q, state_d;
    logic [BITS_ADDR-1:0] fetch_pc_q, fetch_pc_d;
    logic [BITS_ADDR-1:0] mar_q, mar_d;
    logic                 mem_req_q, mem_req_d;
    logic                 pending_q, squash_q;
    logic [BITS_ADDR-1:0] pend_addr_q;

    logic          accepted, held, push, pop, has_room;
    logic [CW-1:0] count;
    logic [EW-1:0] head;
    logic [OW-1:0] occupancy;

    assign accepted = mem_req_q & mem_grant;
    assign held     = mem_req_q & ~mem_grant;
    assign push     = pending_q & ~squash_q;
    assign pop      = ir_valid & ir_ready;

    // Pops are ignored here: a slot is only promised once it is already free.
    assign occupancy = OW'(count) + OW'(pending_q) + OW'(mem_req_q);
    assign has_room  = occupancy < OW'(DEPTH);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mar_d      = mar_q;
        mem_req_d  = mem_req_q;

        case (state_q)
            S_RUN:   if (halt)  state_d = S_HALT;
            default: if (!halt) state_d = S_RUN;
        endcase

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            mem_req_d  = 1'b0;
            if (state_d == S_RUN) begin
                mem_req_d  = 1'b1;
                mar_d      = redirect_pc;
                fetch_pc_d = redirect_pc + 1'b1;
            end
        end else if (!held) begin
            mem_req_d = 1'b0;
            if (state_d == S_RUN && has_room) begin
                mem_req_d  = 1'b1;
                mar_d      = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            fetch_pc_q  <= RESET_PC;
            mar_q       <= '0;
            mem_req_q   <= 1'b0;
            pending_q   <= 1'b0;
            squash_q    <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            mar_q       <= mar_d;
            mem_req_q   <= mem_req_d;
            pending_q   <= accepted;
            squash_q    <= redirect & accepted;
            pend_addr_q <= mar_q;
        end
    end

    prefetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({pend_addr_q, MBR_R}),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

    assign MAR           = mar_q;
    assign mem_req       = mem_req_q;
    assign ir_valid      = count != '0;
    assign {ir_pc, ir}   = ir_valid ? head : '0;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: table-driven stream/grant vectors plus
// hand-written redirect, wrap, halt and mid-transfer reset sequences.
module tb_fetch_prefetch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] MAR;
    logic        mem_req;
    logic        mem_grant;
    logic [31:0] MBR_R;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        ir_valid;
    logic [31:0] ir;
    logic [15:0] ir_pc;
    logic        ir_ready;

    int checks   = 0;
    int failures = 0;

    fetch_prefetch_unit #(
        .BITS_DATA (32),
        .BITS_ADDR (16),
        .DEPTH     (4),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MAR         (MAR),
        .mem_req     (mem_req),
        .mem_grant   (mem_grant),
        .MBR_R       (MBR_R),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'hA000_0000 | {16'h0000, a};
    endfunction

    // Memory: acceptance seen mid-cycle, data driven just after the next edge.
    logic        acc;
    logic [15:0] acc_addr;
    initial begin
        MBR_R = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            acc      = mem_req && mem_grant;
            acc_addr = MAR;
            @(posedge clk);
            #1 MBR_R = acc ? mem_word(acc_addr) : 32'hDEAD_BEEF;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_cycle(input string tag, input logic v, input logic [15:0] pc,
                                input logic req, input logic [15:0] mar);
        check({tag, " ir_valid"}, 32'(ir_valid), 32'(v));
        if (v) begin
            check({tag, " ir_pc"}, 32'(ir_pc), 32'(pc));
            check({tag, " ir"}, ir, mem_word(pc));
        end
        check({tag, " mem_req"}, 32'(mem_req), 32'(req));
        if (req) check({tag, " MAR"}, 32'(MAR), 32'(mar));
    endtask

    task automatic check_reset(input string tag);
        check({tag, " rst MAR"}, 32'(MAR), 32'h0);
        check({tag, " rst mem_req"}, 32'(mem_req), 32'h0);
        check({tag, " rst ir_valid"}, 32'(ir_valid), 32'h0);
        check({tag, " rst ir"}, ir, 32'h0);
        check({tag, " rst ir_pc"}, 32'(ir_pc), 32'h0);
    endtask

    // Leaves the bench in the first cycle with reset low (cycle 0).
    task automatic do_reset(input string tag);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        mem_grant   = 1'b1;
        ir_ready    = 1'b1;
        step();
        reset = 1'b0;
        check_reset(tag);
    endtask

    typedef struct {
        logic        first;
        logic        grant;
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic        exp_req;
        logic [15:0] exp_mar;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // Free-running stream from reset: first word in cycle 3, then one per cycle.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0002};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0003};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0004};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0005};
        // Grant pattern 1,0,0,1 on the second request: address held, none skipped.
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0001};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0003};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0004};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0005};

        reset       = 1'b1;
        mem_grant   = 1'b0;
        ir_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].first) do_reset($sformatf("vec%0d", i));
            expect_cycle($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                         vecs[i].exp_req, vecs[i].exp_mar);
            mem_grant = vecs[i].grant;
            ir_ready  = vecs[i].ready;
            step();
        end

        // Backpressure: FIFO fills to 4, requests stop, order preserved on release.
        do_reset("fill");
        ir_ready = 1'b0;
        expect_cycle("fill c0", 1'b0, 16'h0, 1'b0, 16'h0); step();
        expect_cycle("fill c1", 1'b0, 16'h0, 1'b1, 16'h0); step();
        expect_cycle("fill c2", 1'b0, 16'h0, 1'b1, 16'h1); step();
        expect_cycle("fill c3", 1'b1, 16'h0, 1'b1, 16'h2); step();
        expect_cycle("fill c4", 1'b1, 16'h0, 1'b1, 16'h3); step();
        for (int c = 5; c < 20; c++) begin
            expect_cycle($sformatf("fill c%0d", c), 1'b1, 16'h0, 1'b0, 16'h0);
            step();
        end
        ir_ready = 1'b1;
        expect_cycle("drain c20", 1'b1, 16'h0, 1'b0, 16'h0); step();
        expect_cycle("drain c21", 1'b1, 16'h1, 1'b0, 16'h0); step();
        expect_cycle("drain c22", 1'b1, 16'h2, 1'b1, 16'h4); step();
        expect_cycle("drain c23", 1'b1, 16'h3, 1'b1, 16'h5); step();
        expect_cycle("drain c24", 1'b1, 16'h4, 1'b1, 16'h6); step();
        expect_cycle("drain c25", 1'b1, 16'h5, 1'b1, 16'h7);

        // Redirect with two buffered words, one arriving and one accepted this cycle.
        do_reset("redir");
        ir_ready = 1'b0;
        repeat (4) step();
        expect_cycle("redir pre", 1'b1, 16'h0, 1'b1, 16'h3);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        ir_ready    = 1'b1;
        step();
        redirect = 1'b0;
        expect_cycle("redir +1", 1'b0, 16'h0, 1'b1, 16'h0100); step();
        expect_cycle("redir +2", 1'b0, 16'h0, 1'b1, 16'h0101); step();
        expect_cycle("redir +3", 1'b1, 16'h0100, 1'b1, 16'h0102); step();
        expect_cycle("redir +4", 1'b1, 16'h0101, 1'b1, 16'h0103);

        // Address wrap across 16'hFFFF.
        do_reset("wrap");
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        expect_cycle("wrap +1", 1'b0, 16'h0, 1'b1, 16'hFFFE); step();
        expect_cycle("wrap +2", 1'b0, 16'h0, 1'b1, 16'hFFFF); step();
        expect_cycle("wrap +3", 1'b1, 16'hFFFE, 1'b1, 16'h0000); step();
        expect_cycle("wrap +4", 1'b1, 16'hFFFF, 1'b1, 16'h0001); step();
        expect_cycle("wrap +5", 1'b1, 16'h0000, 1'b1, 16'h0002); step();
        expect_cycle("wrap +6", 1'b1, 16'h0001, 1'b1, 16'h0003);

        // Halt mid-stream, redirect while halted, resume, then reset mid-transfer.
        do_reset("halt");
        repeat (5) step();
        expect_cycle("halt c5", 1'b1, 16'h2, 1'b1, 16'h4);
        halt = 1'b1;
        step();
        expect_cycle("halt c6", 1'b1, 16'h3, 1'b0, 16'h0); step();
        expect_cycle("halt c7", 1'b1, 16'h4, 1'b0, 16'h0); step();
        expect_cycle("halt c8", 1'b0, 16'h0, 1'b0, 16'h0); step();
        expect_cycle("halt c9", 1'b0, 16'h0, 1'b0, 16'h0);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        expect_cycle("halt c10", 1'b0, 16'h0, 1'b0, 16'h0); step();
        expect_cycle("halt c11", 1'b0, 16'h0, 1'b0, 16'h0);
        halt = 1'b0;
        step();
        expect_cycle("resume c12", 1'b0, 16'h0, 1'b1, 16'h0040); step();
        expect_cycle("resume c13", 1'b0, 16'h0, 1'b1, 16'h0041); step();
        expect_cycle("resume c14", 1'b1, 16'h0040, 1'b1, 16'h0042);
        reset = 1'b1;
        step();
        check_reset("midrst");
        reset = 1'b0;
        step();
        expect_cycle("midrst c1", 1'b0, 16'h0, 1'b1, 16'h0); step();
        expect_cycle("midrst c2", 1'b0, 16'h0, 1'b1, 16'h1); step();
        expect_cycle("midrst c3", 1'b1, 16'h0, 1'b1, 16'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
